serial_adder: RTL
=================

// Module: serial_adder
// PURPOSE
//   Bit-serial WIDTH-bit adder: latches two operands plus carry-in, then adds one
//   bit per clock, LSB first, through a single full-adder bit cell and a carry flip-flop.
//   Sits downstream of the combinational adder cells as the area-cheap sequential adder
//   stage; results are consumed by a register or accumulator stage on the done pulse.
// PARAMETERS
//   WIDTH   8   operand / sum width in bits (>= 2)
// PORTS
//   clk        in   1      system clock, all state updates on rising edge
//   rst        in   1      synchronous, active-high reset
//   start      in   1      request: sample a_in/b_in/cin and begin an addition
//   a_in       in   WIDTH  operand A, sampled only when start is accepted
//   b_in       in   WIDTH  operand B, sampled only when start is accepted
//   cin        in   1      carry-in, sampled only when start is accepted
//   busy       out  1      high while bits are being added (SHIFT state)
//   done       out  1      single-cycle pulse: sum/carry valid
//   sum        out  WIDTH  result bits [WIDTH-1:0] of a_in + b_in + cin
//   carry      out  1      carry out of bit WIDTH-1
// BEHAVIOUR
//   - One clock domain; synchronous, active-high reset; no async paths.
//   - Reset: state=IDLE, busy=0, done=0, sum=0, carry=0, internal shift regs, bit counter
//     and carry FF=0. Reset in any state, including mid-SHIFT, aborts the operation.
//     No done pulse is issued for the aborted operation.
//   - FSM states: IDLE, SHIFT, DONE.
//     IDLE : start=1 -> load A/B shift regs and carry FF=cin, clear count -> SHIFT.
//     SHIFT: every edge adds bit A[0]+B[0]+carry_ff. The sum bit shifts into the MSB
//            of the result register (right shift). carry_ff takes cout. A and B shift
//            right, and count increments. The edge that processes bit WIDTH-1 -> DONE.
//     DONE : done=1 for this one cycle. start=1 -> reload, as in IDLE, -> SHIFT
//            (back-to-back). Otherwise -> IDLE.
//   - Latency: start is accepted at edge E0. Bits are processed at edges E1..EWIDTH.
//     done is high in the cycle following EWIDTH, so it goes high exactly WIDTH edges
//     after E0.
//   - sum and carry update only on the transition into DONE, as a full WIDTH-bit word.
//     They hold that value through DONE and any following IDLE until the next result.
//     Partial results are never visible on sum.
//   - start is ignored while busy=1. Operand inputs are don't-care except at acceptance.
//   - Arithmetic is unsigned modulo 2^WIDTH; carry is the (WIDTH+1)th bit.
//   - Counter width is $clog2(WIDTH). Wrap is never reached, because the count is
//     compared to WIDTH-1.
//   - busy=1 exactly in SHIFT. done and busy are never high together.
// STRUCTURE
//   - Shared package / header: state encoding localparams ST_IDLE=2'd0,
//     ST_SHIFT=2'd1, ST_DONE=2'd2.
//   - One sub-module, full_adder_bit (a, b, cin -> sum, cout):
//     sum = a^b^cin, cout = a&b | cin&(a^b). It is instantiated once on the LSBs.
//   - Top level holds the FSM, counter, operand shift regs, carry FF and result register.
// TESTING
//   1. WIDTH=8, a=8'h5A, b=8'h3C, cin=0, start 1 cycle -> busy 8 cycles, then done
//      pulse: sum=8'h96, carry=0.
//   2. a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, carry=1. Also a=8'hFF, b=8'h00, cin=1
//      -> sum=8'h00, carry=1.
//   3. a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, carry=1. Checks full carry chain and cin.
//   4. start pulses with new operands at cycles 2 and 5 of a SHIFT -> ignored. Result
//      matches the first operands, and only one done pulse occurs.
//   5. rst=1 for 1 cycle at bit 4 of an addition -> next cycle: IDLE, busy=0, sum=0,
//      carry=0, no done. A fresh start then yields a correct result.
//   6. start held high continuously with a=8'h01, b=8'h01 -> done pulses every 9
//      cycles, each with sum=8'h02, carry=0. Checks DONE->SHIFT back-to-back.
//   Bench: random 1000-vector compare against a+b+cin for WIDTH=8 and WIDTH=5.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared state encoding for the bit-serial adder.
// The enum values are pinned to the ST_* codes so that waveforms and other tools agree on them.
package serial_adder_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE  = ST_IDLE,
      S_SHIFT = ST_SHIFT,
      S_DONE  = ST_DONE
   } adderState_e;

endpackage

// File: rtl/serial_adder_full_adder_bit.sv
// Single full-adder bit cell. The serial adder uses it on the operand LSBs.
module full_adder_bit (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder. It processes one bit per clock, LSB first, through one full-adder cell.
// sum and carry change only as a complete word when the addition finishes.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             carry
);

   localparam int             CW   = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   adderState_e      state_q, state_d;
   logic [WIDTH-1:0] aReg_q, aReg_d;
   logic [WIDTH-1:0] bReg_q, bReg_d;
   logic [WIDTH-1:0] resReg_q, resReg_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             carry_q, carry_d;
   logic             carryFf_q, carryFf_d;
   logic [CW-1:0]    count_q, count_d;
   logic             faSum, faCout;

   full_adder_bit u_fa (
      .a    (aReg_q[0]),
      .b    (bReg_q[0]),
      .cin  (carryFf_q),
      .sum  (faSum),
      .cout (faCout)
   );

   always_comb begin
      state_d   = state_q;
      aReg_d    = aReg_q;
      bReg_d    = bReg_q;
      resReg_d  = resReg_q;
      sum_d     = sum_q;
      carry_d   = carry_q;
      carryFf_d = carryFf_q;
      count_d   = count_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            state_d = S_IDLE;
            if (start) begin
               state_d   = S_SHIFT;
               aReg_d    = a_in;
               bReg_d    = b_in;
               carryFf_d = cin;
               count_d   = '0;
            end
         end
         S_SHIFT: begin
            aReg_d    = aReg_q >> 1;
            bReg_d    = bReg_q >> 1;
            carryFf_d = faCout;
            resReg_d  = {faSum, resReg_q[WIDTH-1:1]};
            // The last bit is merged straight into the published word so that sum never shows partial results.
            if (count_q == LAST) begin
               state_d = S_DONE;
               sum_d   = {faSum, resReg_q[WIDTH-1:1]};
               carry_d = faCout;
            end else begin
               count_d = count_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         aReg_q    <= '0;
         bReg_q    <= '0;
         resReg_q  <= '0;
         sum_q     <= '0;
         carry_q   <= 1'b0;
         carryFf_q <= 1'b0;
         count_q   <= '0;
      end else begin
         state_q   <= state_d;
         aReg_q    <= aReg_d;
         bReg_q    <= bReg_d;
         resReg_q  <= resReg_d;
         sum_q     <= sum_d;
         carry_q   <= carry_d;
         carryFf_q <= carryFf_d;
         count_q   <= count_d;
      end
   end

   assign busy  = (state_q == S_SHIFT);
   assign done  = (state_q == S_DONE);
   assign sum   = sum_q;
   assign carry = carry_q;

endmodule
